// File: rtl/sram_arb_pkg.sv
// Purpose: shared types and constants for the scratchpad bank port arbiter.
// Latency: RD_LAT is the read latency from the request-accept cycle to rvalid.
// Backpressure: none here; this package only holds types and constants.
// Build option: SRAM_ARB_OUTREG_EN adds an output register stage to read data (RD_LAT = 2).
package sram_arb_pkg;

  // Zero-fill sequencer states.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Which requester a read response belongs to.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

`ifdef SRAM_ARB_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/sram_arb_rr.sv
// Purpose: 2-way round-robin arbiter with a registered priority pointer.
// Latency: the grant is combinational from the requests; the pointer moves on the edge that follows a grant.
// Backpressure: arb_en low masks all grants and holds the pointer.
// Ports: i_clk, i_rstn (synchronous, active low), arb_en, req_vld[1:0] (bit 0 = A, bit 1 = B),
//        gnt[1:0] (one-hot, or zero when nothing is granted).
module sram_arb_rr (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       arb_en,
  input  logic [1:0] req_vld,
  output logic [1:0] gnt
);

  // Set means B has priority, i.e. A was granted last. Reset gives A priority.
  logic prio_b_q;

  always_comb begin
    gnt = 2'b00;
    if (arb_en) begin
      if (req_vld[0] && (!req_vld[1] || !prio_b_q)) begin
        gnt = 2'b01;
      end else if (req_vld[1]) begin
        gnt = 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      prio_b_q <= 1'b0;
    end else if (gnt[0]) begin
      prio_b_q <= 1'b1;
    end else if (gnt[1]) begin
      prio_b_q <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Purpose: arbitrates core port A and DMA port B onto one single-port SRAM bank, and runs a zero-fill clear.
// Latency: a read accepted in cycle N returns rvalid and o_rdata in N+1 (N+2 with SRAM_ARB_OUTREG_EN).
// Backpressure: ready is combinational from the valids. Both readies are held low during a clear.
//               Read responses cannot be stalled.
// Ports: i_clk, i_rstn (synchronous, active low); request ports i_x_valid/o_x_ready/i_x_wen/i_x_addr/
//        i_x_wdata/i_x_be for x = a, b; response ports o_a_rvalid, o_b_rvalid, o_rdata (shared);
//        clear control i_clr_start, o_clr_busy, o_clr_done; bank pins o_cen, o_rdwen, o_addr,
//        o_indata, o_wmask (enables active low), i_outdata.
// Build option: SRAM_ARB_OUTREG_EN registers o_rdata and the rvalids.
module sram_port_arbiter #(
  parameter int ADR_W  = 10,
  parameter int SRAM_W = 128
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_a_valid,
  output logic                o_a_ready,
  input  logic                i_a_wen,
  input  logic [ADR_W-1:0]    i_a_addr,
  input  logic [SRAM_W-1:0]   i_a_wdata,
  input  logic [SRAM_W/8-1:0] i_a_be,
  input  logic                i_b_valid,
  output logic                o_b_ready,
  input  logic                i_b_wen,
  input  logic [ADR_W-1:0]    i_b_addr,
  input  logic [SRAM_W-1:0]   i_b_wdata,
  input  logic [SRAM_W/8-1:0] i_b_be,
  output logic                o_a_rvalid,
  output logic                o_b_rvalid,
  output logic [SRAM_W-1:0]   o_rdata,
  input  logic                i_clr_start,
  output logic                o_clr_busy,
  output logic                o_clr_done,
  output logic                o_cen,
  output logic                o_rdwen,
  output logic [ADR_W-1:0]    o_addr,
  output logic [SRAM_W-1:0]   o_indata,
  output logic [SRAM_W-1:0]   o_wmask,
  input  logic [SRAM_W-1:0]   i_outdata
);

  import sram_arb_pkg::*;

  localparam int               BE_W       = SRAM_W / 8;
  localparam logic [ADR_W-1:0] LAST_ADR   = '1;
  localparam logic [ADR_W-1:0] PENULT_ADR = LAST_ADR - ADR_W'(1);

  clr_state_t       state_q;
  logic [ADR_W-1:0] clr_cnt_q;
  logic             clr_busy_q;
  logic             clr_done_q;

  logic             arb_en;
  logic [1:0]       gnt;

  logic              sel_wen;
  logic [ADR_W-1:0]  sel_addr;
  logic [SRAM_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic [SRAM_W-1:0] sel_mask;

  logic     rd_iss_q;
  port_id_t rd_port_q;

  // Gating with i_rstn keeps readies and the bank idle in the reset cycle itself, so a reset
  // that lands mid-clear does not write one more word.
  assign arb_en = i_rstn && (state_q == IDLE);

  sram_arb_rr u_rr (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .arb_en  (arb_en),
    .req_vld ({i_b_valid, i_a_valid}),
    .gnt     (gnt)
  );

  assign o_a_ready  = gnt[0];
  assign o_b_ready  = gnt[1];
  assign o_clr_busy = clr_busy_q;
  assign o_clr_done = clr_done_q;

  // Payload of the granted port. It defaults to A when nothing is granted; the bank drive below
  // ignores it in that case.
  always_comb begin
    sel_wen   = i_a_wen;
    sel_addr  = i_a_addr;
    sel_wdata = i_a_wdata;
    sel_be    = i_a_be;
    if (gnt[1]) begin
      sel_wen   = i_b_wen;
      sel_addr  = i_b_addr;
      sel_wdata = i_b_wdata;
      sel_be    = i_b_be;
    end
  end

  always_comb begin
    sel_mask = '0;
    for (int k = 0; k < BE_W; k++) begin
      sel_mask[8*k +: 8] = {8{sel_be[k]}};
    end
  end

  // Bank drive. A clear owns the bank. Otherwise the granted request drives it. With no grant
  // every pin is parked at its inactive value.
  always_comb begin
    o_cen    = 1'b1;
    o_rdwen  = 1'b1;
    o_addr   = '0;
    o_indata = '0;
    o_wmask  = '0;
    if (i_rstn && (state_q == CLEAR)) begin
      o_cen    = 1'b0;
      o_rdwen  = 1'b0;
      o_addr   = clr_cnt_q;
      o_wmask  = '1;
    end else if (|gnt) begin
      o_cen    = 1'b0;
      o_rdwen  = ~sel_wen;
      o_addr   = sel_addr;
      o_indata = sel_wdata;
      o_wmask  = sel_wen ? sel_mask : '0;
    end
  end

  // Clear sequencer. The done pulse is registered one address early so that it coincides with
  // the write to the last address.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_clr_start) begin
            state_q    <= CLEAR;
            clr_busy_q <= 1'b1;
            clr_cnt_q  <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt_q == LAST_ADR) begin
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
            clr_cnt_q  <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADR_W'(1);
            if (clr_cnt_q == PENULT_ADR) begin
              clr_done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Read issue tracking: at most one access per cycle, so a single flag plus a port ID is enough
  // to steer the bank's next-cycle data.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rd_iss_q  <= 1'b0;
      rd_port_q <= PORT_A;
    end else begin
      rd_iss_q  <= (|gnt) && !sel_wen;
      rd_port_q <= gnt[1] ? PORT_B : PORT_A;
    end
  end

`ifdef SRAM_ARB_OUTREG_EN
  logic              a_rv_q;
  logic              b_rv_q;
  logic [SRAM_W-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      a_rv_q <= rd_iss_q && (rd_port_q == PORT_A);
      b_rv_q <= rd_iss_q && (rd_port_q == PORT_B);
      if (rd_iss_q) begin
        rdata_q <= i_outdata;
      end
    end
  end

  assign o_a_rvalid = i_rstn && a_rv_q;
  assign o_b_rvalid = i_rstn && b_rv_q;
  assign o_rdata    = rdata_q;
`else
  assign o_a_rvalid = i_rstn && rd_iss_q && (rd_port_q == PORT_A);
  assign o_b_rvalid = i_rstn && rd_iss_q && (rd_port_q == PORT_B);
  assign o_rdata    = i_outdata;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Purpose: bench for sram_port_arbiter. It holds a behavioural bank, a reference memory model,
// and directed plus random request streams.
// Latency: expected rvalid timing comes from the package RD_LAT.
// Backpressure: the request queues hold each payload until the model's grant rule accepts it.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int ADR_W  = 8;
  localparam int SRAM_W = 32;
  localparam int DEPTH  = 256;

  logic        clk = 1'b0;
  logic        rstn;
  logic        a_valid, a_ready, a_wen, b_valid, b_ready, b_wen;
  logic [7:0]  a_addr, b_addr, addr;
  logic [31:0] a_wdata, b_wdata, rdata, indata, wmask, outdata;
  logic [3:0]  a_be, b_be;
  logic        a_rvalid, b_rvalid, clr_start, clr_busy, clr_done, cen, rdwen;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADR_W(ADR_W), .SRAM_W(SRAM_W)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_wen(a_wen), .i_a_addr(a_addr),
    .i_a_wdata(a_wdata), .i_a_be(a_be),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_wen(b_wen), .i_b_addr(b_addr),
    .i_b_wdata(b_wdata), .i_b_be(b_be),
    .o_a_rvalid(a_rvalid), .o_b_rvalid(b_rvalid), .o_rdata(rdata),
    .i_clr_start(clr_start), .o_clr_busy(clr_busy), .o_clr_done(clr_done),
    .o_cen(cen), .o_rdwen(rdwen), .o_addr(addr), .o_indata(indata), .o_wmask(wmask),
    .i_outdata(outdata)
  );

  // Behavioural single-port bank: masked write, registered read.
  logic [31:0] bank [DEPTH];
  always @(posedge clk) begin
    if (!cen) begin
      if (!rdwen) bank[addr] <= (bank[addr] & ~wmask) | (indata & wmask);
      else        outdata    <= bank[addr];
    end
  end

  typedef struct {bit wen; logic [7:0] addr; logic [31:0] wdata; logic [3:0] be;} req_t;
  typedef struct {int due; bit port; logic [31:0] data;} rsp_t;

  // Reference model state.
  logic [31:0] exp_mem [DEPTH];
  bit          last_b;
  bit          clr_active;
  int          clr_addr;
  int          cyc;
  rsp_t        pend[$];
  req_t        qa[$], qb[$];
  int          glog[$];
  bit          acc_a, acc_b;
  logic [31:0] last_rdata;
  int          busy_cnt, done_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] be2mask(input logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  task automatic apply(input bit port, input bit wen, input logic [7:0] ad,
                       input logic [31:0] wd, input logic [3:0] be);
    if (wen) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) exp_mem[ad][8*k +: 8] = wd[8*k +: 8];
    end else begin
      pend.push_back('{cyc + RD_LAT, port, exp_mem[ad]});
    end
    last_b = port;
  endtask

  task automatic drive();
    if (qa.size() > 0) begin
      a_valid = 1'b1; a_wen = qa[0].wen; a_addr = qa[0].addr; a_wdata = qa[0].wdata; a_be = qa[0].be;
    end else begin
      a_valid = 1'b0; a_wen = 1'($urandom); a_addr = 8'($urandom); a_wdata = $urandom; a_be = 4'($urandom);
    end
    if (qb.size() > 0) begin
      b_valid = 1'b1; b_wen = qb[0].wen; b_addr = qb[0].addr; b_wdata = qb[0].wdata; b_be = qb[0].be;
    end else begin
      b_valid = 1'b0; b_wen = 1'($urandom); b_addr = 8'($urandom); b_wdata = $urandom; b_be = 4'($urandom);
    end
  endtask

  // One clock cycle: compare every output at the falling edge, then advance the model.
  task automatic step();
    bit ga, gb, ra, rb;
    logic [73:0] exp_bank;
    @(negedge clk);
    ga = !clr_active && a_valid && (!b_valid || last_b);
    gb = !clr_active && b_valid && (!a_valid || !last_b);
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    if (a_ready) glog.push_back(0);
    if (b_ready) glog.push_back(1);
    ra = pend.size() > 0 && pend[0].due == cyc && pend[0].port == 1'b0;
    rb = pend.size() > 0 && pend[0].due == cyc && pend[0].port == 1'b1;
    chk("a_rvalid", a_rvalid, ra);
    chk("b_rvalid", b_rvalid, rb);
    if (ra || rb) begin
      chk("rdata", rdata, pend[0].data);
      last_rdata = rdata;
      void'(pend.pop_front());
    end
    chk("clr_busy", clr_busy, clr_active);
    chk("clr_done", clr_done, clr_active && clr_addr == DEPTH - 1);
    busy_cnt += int'(clr_busy);
    done_cnt += int'(clr_done);
    if (clr_active)  exp_bank = {1'b0, 1'b0, 8'(clr_addr), 32'h0, 32'hFFFF_FFFF};
    else if (ga)     exp_bank = {1'b0, !a_wen, a_addr, a_wdata, a_wen ? be2mask(a_be) : 32'h0};
    else if (gb)     exp_bank = {1'b0, !b_wen, b_addr, b_wdata, b_wen ? be2mask(b_be) : 32'h0};
    else             exp_bank = {1'b1, 1'b1, 8'h0, 32'h0, 32'h0};
    chk("bank", {cen, rdwen, addr, indata, wmask}, exp_bank);
    if (ga) apply(1'b0, a_wen, a_addr, a_wdata, a_be);
    if (gb) apply(1'b1, b_wen, b_addr, b_wdata, b_be);
    acc_a = ga;
    acc_b = gb;
    if (clr_active) begin
      exp_mem[clr_addr] = 32'h0;
      if (clr_addr == DEPTH - 1) clr_active = 1'b0;
      else clr_addr++;
    end else if (clr_start) begin
      clr_active = 1'b1;
      clr_addr   = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Play the request queues (and optionally a clear start) until everything has drained.
  // Spurious starts are thrown in while a clear is running; the DUT must ignore them.
  task automatic run(input int max_cyc, input bit start_clr);
    int n;
    bit first;
    n = 0;
    first = start_clr;
    while ((qa.size() > 0 || qb.size() > 0 || pend.size() > 0 || clr_active || first) && n < max_cyc) begin
      drive();
      clr_start = first ? 1'b1 : (clr_active ? 1'($urandom_range(0, 1)) : 1'b0);
      first = 1'b0;
      step();
      if (acc_a) void'(qa.pop_front());
      if (acc_b) void'(qb.pop_front());
      n++;
    end
    clr_start = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    chk("drain", qa.size() + qb.size() + pend.size() + int'(clr_active), 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0; a_valid = 1'b0; b_valid = 1'b0; clr_start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rstn = 1'b1;
    pend.delete();
    clr_active = 1'b0;
    clr_addr   = 0;
    last_b     = 1'b1;
  endtask

  initial begin
    cyc = 0; last_b = 1'b1; clr_active = 1'b0; clr_addr = 0;
    busy_cnt = 0; done_cnt = 0; last_rdata = '0;
    a_wen = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_wen = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    do_reset();

    // Reset state, then zero the bank so that model and bank start out identical.
    step();
    run(400, 1'b1);
    chk("init_busy_cycles", busy_cnt, DEPTH);
    chk("init_done_pulses", done_cnt, 1);

    // Single read after a write.
    qa.push_back('{1'b1, 8'd5, 32'hDEAD_BEEF, 4'hF});
    qa.push_back('{1'b0, 8'd5, 32'h0, 4'h0});
    run(20, 1'b0);
    chk("single_read", last_rdata, 32'hDEAD_BEEF);

    // Contention: 4 reads per port back-to-back. A lone B write first gives A priority.
    for (int i = 0; i < 4; i++) begin
      qa.push_back('{1'b1, 8'(10 + i), $urandom, 4'hF});
      qb.push_back('{1'b1, 8'(14 + i), $urandom, 4'hF});
    end
    run(30, 1'b0);
    qb.push_back('{1'b1, 8'd18, 32'h1818_1818, 4'hF});
    run(10, 1'b0);
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      qa.push_back('{1'b0, 8'(10 + i), 32'h0, 4'h0});
      qb.push_back('{1'b0, 8'(14 + i), 32'h0, 4'h0});
    end
    run(30, 1'b0);
    chk("grant_count", glog.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < glog.size()) chk("grant_order", glog[i], i % 2);

    // Byte enables.
    qa.push_back('{1'b1, 8'd3, 32'hFFFF_FFFF, 4'hF});
    qa.push_back('{1'b1, 8'd3, 32'h0, 4'h1});
    qa.push_back('{1'b0, 8'd3, 32'h0, 4'h0});
    run(20, 1'b0);
    chk("byte_enable", last_rdata, 32'hFFFF_FF00);

    // Random mixed traffic on both ports.
    for (int n = 0; n < 300; n++) begin
      if (qa.size() < 2 && $urandom_range(0, 1) == 1)
        qa.push_back('{1'($urandom), 8'($urandom_range(0, 31)), $urandom, 4'($urandom)});
      if (qb.size() < 2 && $urandom_range(0, 1) == 1)
        qb.push_back('{1'($urandom), 8'($urandom_range(0, 31)), $urandom, 4'($urandom)});
      drive();
      step();
      if (acc_a) void'(qa.pop_front());
      if (acc_b) void'(qb.pop_front());
    end
    run(50, 1'b0);

    // Fill 16 words, then start a clear in the same cycle that read requests are presented.
    for (int i = 0; i < 16; i++) qa.push_back('{1'b1, 8'(i), 32'h0101_0101 * (i + 1), 4'hF});
    run(40, 1'b0);
    qa.push_back('{1'b0, 8'd7, 32'h0, 4'h0});
    qb.push_back('{1'b0, 8'd8, 32'h0, 4'h0});
    busy_cnt = 0;
    done_cnt = 0;
    run(400, 1'b1);
    chk("clr_busy_cycles", busy_cnt, DEPTH);
    chk("clr_done_pulses", done_cnt, 1);
    for (int i = 0; i < 16; i++) qb.push_back('{1'b0, 8'(i), 32'h0, 4'h0});
    run(40, 1'b0);
    chk("clr_zero", last_rdata, 32'h0);

    // Reset while the clear is at address 100.
    qa.push_back('{1'b1, 8'd99, 32'h1234_5678, 4'hF});
    qa.push_back('{1'b1, 8'd200, 32'hCAFE_F00D, 4'hF});
    run(20, 1'b0);
    done_cnt = 0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int n = 0; n < 300 && clr_active && clr_addr != 100; n++) step();
    chk("clr_reached_100", clr_addr, 100);
    do_reset();
    step();
    chk("rst_no_done", done_cnt, 0);
    qa.push_back('{1'b0, 8'd99, 32'h0, 4'h0});
    run(20, 1'b0);
    chk("addr99_cleared", last_rdata, 32'h0);
    qa.push_back('{1'b0, 8'd200, 32'h0, 4'h0});
    run(20, 1'b0);
    chk("addr200_kept", last_rdata, 32'hCAFE_F00D);

    // Reset with a read in flight: its rvalid must not appear afterwards.
    qa.push_back('{1'b0, 8'd5, 32'h0, 4'h0});
    drive();
    step();
    chk("inflight_grant", acc_a, 1'b1);
    if (acc_a) void'(qa.pop_front());
    do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester controller for one single-port scratchpad SRAM bank of the SAURIA core. It arbitrates a core-side port (A) and a DMA-side port (B) onto the bank's active-low chip-enable/write-enable interface using round-robin arbitration. It routes 1-cycle-latency read data back to the issuing port and provides a hardware clear sequence that zero-fills the whole bank. It sits between the feeder/DMA logic and the bank instance, one arbiter per bank.

## Interface
- ADR_W, 10, bank address width (depth 2**ADR_W words)
- SRAM_W, 128, word width in bits; multiple of 8
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_a_valid / i_b_valid  in  1  request valid, per port
- o_a_ready / o_b_ready  out  1  request accepted this cycle
- i_a_wen / i_b_wen  in  1  1 = write, 0 = read
- i_a_addr / i_b_addr  in  ADR_W  word address
- i_a_wdata / i_b_wdata  in  SRAM_W  write data
- i_a_be / i_b_be  in  SRAM_W/8  byte enables (writes only)
- o_a_rvalid / o_b_rvalid  out  1  read data valid for that port
- o_rdata  out  SRAM_W  read data, shared, qualified by rvalid
- i_clr_start  in  1  start zero-fill; pulse
- o_clr_busy  out  1  clear in progress
- o_clr_done  out  1  one-cycle pulse at end of clear
- o_cen  out  1  bank chip enable, active low
- o_rdwen  out  1  bank write enable, active low (0 = write)
- o_addr  out  ADR_W  bank address
- o_indata  out  SRAM_W  bank write data
- o_wmask  out  SRAM_W  bank bit mask
- i_outdata  in  SRAM_W  bank read data, valid the cycle after a read issue

## Operation
- Handshake: a transfer occurs when valid && ready. A requester holds valid and its payload stable until ready. Ready is combinational from both valids and the priority pointer. The valid-to-ready path is allowed; the ready-to-valid path is forbidden.
- Arbitration: when one port is valid, it is granted. When both are valid, the port not granted last wins. The pointer updates only on a grant. Reset pointer favours A.
- Bank drive (combinational from the grant):
  - Grant: o_cen=0, o_rdwen=~wen, o_addr=addr, o_indata=wdata.
  - o_wmask byte k = {8{be[k]}} on writes, all 0 on reads.
  - No grant: o_cen=1, o_rdwen=1, o_addr=0, o_indata=0, o_wmask=0.
- Read return: a 1-bit issue flag plus a port ID are registered on each read grant. The matching rvalid asserts with o_rdata=i_outdata. There is no response backpressure; requesters must always accept. Responses return in issue order.
- Writes produce no response.
- Clear FSM states: IDLE, CLEAR.
  - IDLE→CLEAR on i_clr_start. i_clr_start is ignored while in CLEAR.
  - In CLEAR, both readies are 0. Each cycle the FSM writes 0 with full mask at counter address, then increments.
  - At address 2**ADR_W-1 the FSM issues the last write, pulses o_clr_done in that same cycle, and returns to IDLE.
  - o_clr_busy = (state==CLEAR).
- A start arriving with valid requests: clear takes the bank from the next cycle. The grant in the start cycle proceeds normally. Reads already in flight still return.

## Timing
- Request accepted in cycle N: the bank samples it at the N/N+1 edge. Read rvalid/o_rdata appear in N+1 (latency 1).
- Full throughput: one access per cycle, back-to-back, mixed ports and directions.
- Clear duration: 2**ADR_W cycles after the start cycle. First ready in the cycle after o_clr_done.
- Reset values: o_a_ready=o_b_ready=0, o_a_rvalid=o_b_rvalid=0, o_rdata=0 (registered variant only), o_clr_busy=0, o_clr_done=0, o_cen=1, o_rdwen=1, o_addr=0, o_indata=0, o_wmask=0. Pointer=A, FSM=IDLE, counter=0.
- Reset mid-clear: FSM returns to IDLE and the counter to 0. Partially cleared contents stay as written. No o_clr_done.
- Reset with a read in flight: the rvalid is dropped.

## Configuration
- SRAM_ARB_OUTREG_EN
- Defined: o_rdata and the rvalids gain one register stage. Read latency is 2 cycles, o_rdata resets to 0, and the issue pipeline is 2 deep.
- Undefined: o_rdata is a combinational pass-through of i_outdata (not reset) and read latency is 1.
- Throughput and arbitration are identical in both builds.

## Structure
- Package sram_arb_pkg holds:
  - the clear FSM state enum (IDLE, CLEAR)
  - the port-ID typedef (PORT_A, PORT_B)
  - localparam RD_LAT (1 or 2, set by the macro)
- Sub-module sram_arb_rr: 2-way round-robin arbiter (valids in, one-hot grant out, registered pointer, update on grant).

## Test plan
- Single read: A reads addr 5 after writing 0xDEAD_BEEF there. A rvalid in N+1 (N+2 with OUTREG) with that data; B rvalid stays 0.
- Contention: both ports issue 4 back-to-back reads. Grants alternate A,B,A,B,A,B,A,B; each rvalid carries the correct port's data.
- Byte enables: write all-0xFF, then write 0x00 with be=0x0001 to addr 3. Read returns 0xFF..FF00.
- Clear: fill 16 addresses, pulse i_clr_start. Readies are low for 2**ADR_W cycles, o_clr_done is one cycle, and all reads then return 0.
- Reset at clear address 100: FSM is IDLE, no done pulse. Addr 99 reads 0; addr 200 keeps its old data.
- Start coinciding with a read grant: the read completes with correct data and clear begins next cycle.
